// File: rtl/count_event_logger.sv
// Watches counter samples for wrap/threshold/direction events and queues them for a valid/ready sink.
// Event visible on evt_valid 1 cycle after its sample; COUNT_EVT_STEP_CHECK_EN adds STEP_ERR (code 4).
module count_event_logger #(
  parameter int               WIDTH  = 8,
  parameter int               DEPTH  = 4,
  parameter logic [WIDTH-1:0] THRESH = 8'd128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_down,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       evt_ready,
  input  logic                       clr_ovf,
  output logic                       evt_valid,
  output logic [2:0]                 evt_code,
  output logic [WIDTH-1:0]           evt_count,
  output logic                       ovf,
  output logic [7:0]                 drop_cnt,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [WIDTH-1:0] MAXV = '1;

  typedef enum logic {S_PRIME, S_RUN} state_t;

  typedef struct packed {
    logic [2:0]       code;
    logic [WIDTH-1:0] cnt;
  } entry_t;

  state_t           state_q;
  logic [WIDTH-1:0] prev_count_q;
  logic             prev_dir_q;
  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  entry_t           head_q, head_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;

  logic   run;
  logic   ev_wrap_up, ev_wrap_dn, ev_thr, ev_dir, ev_step;
  logic [2:0] n_ev;
  logic   push_req, do_push, do_pop, lost;
  entry_t push_ent;
  logic [2:0] drop_inc;
  logic [8:0] drop_sum;

  always_comb begin
    run        = (state_q == S_RUN);
    ev_wrap_up = run && up_down && (prev_count_q == MAXV) && (count_in == '0);
    ev_wrap_dn = run && !up_down && (prev_count_q == '0) && (count_in == MAXV);
    ev_thr     = run && (count_in == THRESH) && (prev_count_q != THRESH);
    ev_dir     = run && (up_down != prev_dir_q);
`ifdef COUNT_EVT_STEP_CHECK_EN
    // Wraps fall out naturally from modular +/-1, so they are never step errors.
    ev_step    = run && !ev_dir &&
                 (up_down ? (count_in != prev_count_q + WIDTH'(1))
                          : (count_in != prev_count_q - WIDTH'(1)));
`else
    ev_step    = 1'b0;
`endif
    n_ev = 3'(ev_step) + 3'(ev_wrap_up) + 3'(ev_wrap_dn) + 3'(ev_thr) + 3'(ev_dir);
    push_req = (n_ev != 3'd0);

    push_ent.cnt = count_in;
    if (ev_step)         push_ent.code = 3'd4;
    else if (ev_wrap_up) push_ent.code = 3'd0;
    else if (ev_wrap_dn) push_ent.code = 3'd1;
    else if (ev_thr)     push_ent.code = 3'd2;
    else                 push_ent.code = 3'd3;

    do_pop  = (level_q != '0) && evt_ready;
    do_push = push_req && ((level_q != LW'(DEPTH)) || do_pop);
    lost    = push_req && !do_push;

    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);

    // Head register keeps the last entry visible once the queue drains.
    if (level_d == '0)
      head_d = head_q;
    else if ((level_q - LW'(do_pop)) == '0)
      head_d = push_ent;
    else
      head_d = mem_q[rd_ptr_d];

    drop_inc = (push_req ? n_ev - 3'd1 : 3'd0) + 3'(lost);
    drop_sum = {1'b0, drop_q} + 9'(drop_inc);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    ovf_d = lost ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PRIME;
      prev_count_q <= '0;
      prev_dir_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      head_q       <= '0;
      ovf_q        <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= S_RUN;
      prev_count_q <= count_in;
      prev_dir_q   <= up_down;
      wr_ptr_q     <= wr_ptr_q + PW'(do_push);
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      head_q       <= head_d;
      ovf_q        <= ovf_d;
      drop_q       <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= push_ent;
  end

  assign evt_valid = (level_q != '0);
  assign evt_code  = head_q.code;
  assign evt_count = head_q.cnt;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_q;
  assign level     = level_q;

endmodule
